// File: rtl/fork_join_scheduler_pkg.sv
//------------------------------------------------------------------------------
// Module   : fork_pkg
// Brief    : Shared types and defaults for the fork/join scheduler.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fork_pkg;

    localparam int C_DEFAULT_N_TASKS = 2;
    localparam int C_DEFAULT_DUR_W   = 8;

    typedef enum logic [1:0] {
        JOIN      = 2'd0,
        JOIN_ANY  = 2'd1,
        JOIN_NONE = 2'd2
    } fork_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fsm_state_e;

    // The reserved encoding falls back to a full join.
    function automatic fork_mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return JOIN_ANY;
            2'd2:    return JOIN_NONE;
            default: return JOIN;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/fork_join_scheduler_if.sv
//------------------------------------------------------------------------------
// Module   : fork_join_scheduler_if
// Brief    : Command and worker signalling bundle of the fork/join scheduler.
//            FORK_DISABLE_EN adds the kill / fork_killed pair.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fork_join_scheduler_if #(
    parameter int N_TASKS = 2,
    parameter int DUR_W   = 8
);
    logic                       fork_valid;
    logic                       fork_ready;
    logic [1:0]                 fork_mode;
    logic [N_TASKS-1:0]         fork_mask;
    logic [N_TASKS*DUR_W-1:0]   fork_dur;
    logic [N_TASKS-1:0]         task_start;
    logic [N_TASKS-1:0]         task_active;
    logic [N_TASKS-1:0]         task_done;
    logic                       join_done;
`ifdef FORK_DISABLE_EN
    logic                       kill;
    logic                       fork_killed;
`endif

    modport master (
        output fork_valid,
        output fork_mode,
        output fork_mask,
        output fork_dur,
        input  fork_ready,
        input  task_start,
        input  task_active,
        input  task_done,
        input  join_done
`ifdef FORK_DISABLE_EN
        ,
        output kill,
        input  fork_killed
`endif
    );

    modport slave (
        input  fork_valid,
        input  fork_mode,
        input  fork_mask,
        input  fork_dur,
        output fork_ready,
        output task_start,
        output task_active,
        output task_done,
        output join_done
`ifdef FORK_DISABLE_EN
        ,
        input  kill,
        output fork_killed
`endif
    );

endinterface

`default_nettype wire

// File: rtl/fork_join_scheduler_task_timer.sv
//------------------------------------------------------------------------------
// Module   : task_timer
// Brief    : One worker timer: start pulse, DUR cycles active, done pulse.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module task_timer #(
    parameter int DUR_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [DUR_W-1:0] duration,
    input  wire logic             clear,
    output logic                  start,
    output logic                  active,
    output logic                  done,
    output logic                  done_next
);

    logic [DUR_W-1:0] r_cnt;
    logic             r_start;
    logic             r_active;
    logic             r_done;
    logic [DUR_W-1:0] w_cnt_next;
    logic             w_start_next;
    logic             w_active_next;
    logic             w_done_next;

    // Active spans the start cycle, so the counter holds remaining cycles minus one.
    always_comb begin
        w_cnt_next    = r_cnt;
        w_start_next  = 1'b0;
        w_active_next = r_active;
        w_done_next   = 1'b0;
        if (clear) begin
            w_active_next = 1'b0;
        end else if (load) begin
            w_start_next = 1'b1;
            if (duration == '0) begin
                w_done_next   = 1'b1;
                w_active_next = 1'b0;
            end else begin
                w_active_next = 1'b1;
                w_cnt_next    = duration - DUR_W'(1);
            end
        end else if (r_active) begin
            if (r_cnt == '0) begin
                w_active_next = 1'b0;
                w_done_next   = 1'b1;
            end else begin
                w_cnt_next = r_cnt - DUR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_start  <= 1'b0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_start  <= w_start_next;
            r_active <= w_active_next;
            r_done   <= w_done_next;
        end
    end

    assign start     = r_start;
    assign active    = r_active;
    assign done      = r_done;
    assign done_next = w_done_next;

endmodule

`default_nettype wire

// File: rtl/fork_join_scheduler.sv
//------------------------------------------------------------------------------
// Module   : fork_join_scheduler
// Brief    : Fork/join controller: launches timed workers, reports the join point.
//            Optional abort support with FORK_DISABLE_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fork_join_scheduler
    import fork_pkg::*;
#(
    parameter int N_TASKS = C_DEFAULT_N_TASKS,
    parameter int DUR_W   = C_DEFAULT_DUR_W
) (
    input  wire logic              clk,
    input  wire logic              rst,
    fork_join_scheduler_if.slave   bus
);

    fsm_state_e         r_state;
    fsm_state_e         w_state_next;
    fork_mode_e         r_mode;
    fork_mode_e         w_mode;
    logic [N_TASKS-1:0] r_rem;
    logic [N_TASKS-1:0] w_rem_cur;
    logic [N_TASKS-1:0] w_rem_next;
    logic               r_joined;
    logic               r_join_done;
    logic               w_join_next;
    logic               w_hit;
    logic               w_accept;
    logic               w_clear;
    logic [N_TASKS-1:0] w_load;
    logic [N_TASKS-1:0] w_start;
    logic [N_TASKS-1:0] w_active;
    logic [N_TASKS-1:0] w_done;
    logic [N_TASKS-1:0] w_done_next;

    assign w_accept = bus.fork_valid && (r_state == IDLE);
    assign w_load   = {N_TASKS{w_accept}} & bus.fork_mask;

`ifdef FORK_DISABLE_EN
    logic r_fork_killed;

    // A held kill aborts once; the following cycle only drains back to IDLE.
    assign w_clear = bus.kill && (r_state != IDLE) && !r_fork_killed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fork_killed <= 1'b0;
        end else begin
            r_fork_killed <= w_clear;
        end
    end

    assign bus.fork_killed = r_fork_killed;
`else
    assign w_clear = 1'b0;
`endif

    generate
        for (genvar i = 0; i < N_TASKS; i++) begin : g_task
            task_timer #(
                .DUR_W (DUR_W)
            ) u_timer (
                .clk       (clk),
                .rst       (rst),
                .load      (w_load[i]),
                .duration  (bus.fork_dur[i*DUR_W +: DUR_W]),
                .clear     (w_clear),
                .start     (w_start[i]),
                .active    (w_active[i]),
                .done      (w_done[i]),
                .done_next (w_done_next[i])
            );
        end
    endgenerate

    // Join is judged on the timers' next done so join_done lines up with task_done.
    always_comb begin
        w_mode     = w_accept ? decode_mode(bus.fork_mode) : r_mode;
        w_rem_cur  = w_accept ? bus.fork_mask : r_rem;
        w_rem_next = w_rem_cur & ~w_done_next;
        w_hit      = 1'b0;
        if (w_accept && ((bus.fork_mask == '0) || (w_mode == JOIN_NONE))) begin
            w_hit = 1'b1;
        end else begin
            case (w_mode)
                JOIN_ANY: w_hit = |w_done_next;
                JOIN:     w_hit = (|w_done_next) && (w_rem_next == '0);
                default:  w_hit = 1'b0;
            endcase
        end
        w_join_next = w_hit && (w_accept || ((r_state != IDLE) && !r_joined));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode      <= JOIN;
            r_rem       <= '0;
            r_joined    <= 1'b0;
            r_join_done <= 1'b0;
        end else begin
            r_mode      <= w_mode;
            r_rem       <= w_rem_next;
            r_joined    <= w_accept ? w_join_next : (r_joined | w_join_next);
            r_join_done <= w_join_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (!(|w_active)) begin
                    w_state_next = IDLE;
                end else if (r_joined) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!(|w_active)) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign bus.fork_ready  = (r_state == IDLE);
    assign bus.task_start  = w_start;
    assign bus.task_active = w_active;
    assign bus.task_done   = w_done;
    assign bus.join_done   = r_join_done;

endmodule

`default_nettype wire

// File: tb/tb_fork_join_scheduler.sv
//------------------------------------------------------------------------------
// Module   : tb_fork_join_scheduler
// Brief    : Randomised cycle-accurate check of the fork/join scheduler.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fork_join_scheduler;

    localparam int N  = 2;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fork_join_scheduler_if #(.N_TASKS(N), .DUR_W(DW)) bus ();

    fork_join_scheduler #(.N_TASKS(N), .DUR_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference: the last accepted fork, described by its accept cycle and parameters.
    bit         m_have = 1'b0;
    int         m_t    = 0;
    int         m_mode = 0;
    logic [N-1:0] m_mask = '0;
    int         m_dur [N];
    int         m_kill = -1;
    bit         acc_flag = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int max_dur();
        int mx = 0;
        for (int i = 0; i < N; i++)
            if (m_mask[i] && m_dur[i] > mx) mx = m_dur[i];
        return mx;
    endfunction

    function automatic int min_dur();
        int mn = 1 << 30;
        for (int i = 0; i < N; i++)
            if (m_mask[i] && m_dur[i] < mn) mn = m_dur[i];
        return mn;
    endfunction

    task automatic model_outputs(input int c, output logic [N-1:0] s, output logic [N-1:0] a,
                                 output logic [N-1:0] d, output logic j, output logic r,
                                 output logic kl);
        int k;
        int jc;
        s = '0; a = '0; d = '0; j = 1'b0; r = 1'b1; kl = 1'b0;
        if (m_have) begin
            k = c - m_t;
            for (int i = 0; i < N; i++) begin
                if (m_mask[i]) begin
                    s[i] = (k == 1);
                    a[i] = (k >= 1) && (k <= m_dur[i]);
                    d[i] = (k == 1 + m_dur[i]);
                end
            end
            if (m_mask == '0 || m_mode == 2) jc = 1;
            else if (m_mode == 1)            jc = 1 + min_dur();
            else                             jc = 1 + max_dur();
            j = (k == jc);
            r = !((k >= 1) && (k <= 1 + max_dur()));
            if (m_kill >= 0 && c > m_kill) begin
                s = '0; a = '0; d = '0; j = 1'b0;
                r  = (c >= m_kill + 2);
                kl = (c == m_kill + 1);
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] es, ea, ed;
        logic ej, er, ek;
        model_outputs(cyc, es, ea, ed, ej, er, ek);
        check_eq("task_start",  32'(bus.task_start),  32'(es));
        check_eq("task_active", 32'(bus.task_active), 32'(ea));
        check_eq("task_done",   32'(bus.task_done),   32'(ed));
        check_eq("join_done",   32'(bus.join_done),   32'(ej));
        check_eq("fork_ready",  32'(bus.fork_ready),  32'(er));
`ifdef FORK_DISABLE_EN
        check_eq("fork_killed", 32'(bus.fork_killed), 32'(ek));
`endif
    endtask

    // Called at the negedge of cycle cyc; returns at the negedge of cycle cyc+1.
    task automatic step();
        logic [N-1:0] es, ea, ed;
        logic ej, er, ek;
        int k;
        check_outputs();
        model_outputs(cyc, es, ea, ed, ej, er, ek);
        acc_flag = 1'b0;
`ifdef FORK_DISABLE_EN
        if (bus.kill && m_have && m_kill < 0) begin
            k = cyc - m_t;
            if (k >= 1 && k <= max_dur()) m_kill = cyc;
        end
`endif
        if (!rst && bus.fork_valid && er) begin
            m_have   = 1'b1;
            m_t      = cyc;
            m_mode   = int'(bus.fork_mode);
            m_mask   = bus.fork_mask;
            for (int i = 0; i < N; i++) m_dur[i] = int'(bus.fork_dur[i*DW +: DW]);
            m_kill   = -1;
            acc_flag = 1'b1;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic issue(input int mode, input logic [N-1:0] mask, input int d0, input int d1);
        logic [1:0] mv;
        int budget = 0;
        mv = 2'(mode);
        bus.fork_valid = 1'b1;
        bus.fork_mode  = mv;
        bus.fork_mask  = mask;
        bus.fork_dur   = {DW'(d1), DW'(d0)};
        acc_flag       = 1'b0;
        while (!acc_flag && budget < 400) begin
            step();
            budget++;
        end
        if (!acc_flag) check_eq("accept_timeout", 32'd0, 32'd1);
        bus.fork_valid = 1'b0;
    endtask

    task automatic do_reset();
        check_outputs();
        rst = 1'b1;
        #1;
        m_have = 1'b0;
        m_kill = -1;
        check_outputs();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef FORK_DISABLE_EN
    task automatic pulse_kill();
        bus.kill = 1'b1;
        step();
        bus.kill = 1'b0;
    endtask
`endif

    initial begin
        int mode, d0, d1, gap, kd, mx;
        logic [N-1:0] mask;
        bus.fork_valid = 1'b0;
        bus.fork_mode  = 2'd0;
        bus.fork_mask  = '0;
        bus.fork_dur   = '0;
`ifdef FORK_DISABLE_EN
        bus.kill = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
        cyc = 0;

        // Directed scenarios
        issue(0, 2'b11, 20, 30);
        idle(35);
        issue(2, 2'b11, 20, 30);
        idle(3);
        issue(0, 2'b01, 4, 0);
        idle(10);
        issue(1, 2'b11, 5, 5);
        idle(8);
        issue(1, 2'b00, 7, 7);
        idle(3);
        issue(0, 2'b00, 7, 7);
        idle(3);
        issue(2, 2'b00, 7, 7);
        idle(3);
        issue(3, 2'b11, 0, 3);
        idle(6);
        issue(0, 2'b11, 0, 0);
        idle(3);
        issue(0, 2'b11, 20, 30);
        idle(8);
        do_reset();
        idle(40);
`ifdef FORK_DISABLE_EN
        issue(0, 2'b11, 20, 30);
        idle(19);
        pulse_kill();
        idle(5);
        pulse_kill();
        idle(3);
`endif

        // Randomised forks, sometimes back-to-back with fork_valid held
        for (int n = 0; n < 60; n++) begin
            mode = int'($urandom_range(0, 3));
            mask = N'($urandom_range(0, 3));
            d0   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 80)) : int'($urandom_range(0, 15));
            d1   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 80)) : int'($urandom_range(0, 15));
            issue(mode, mask, d0, d1);
`ifdef FORK_DISABLE_EN
            mx = max_dur();
            if (mx >= 1 && $urandom_range(0, 3) == 0) begin
                kd = int'($urandom_range(1, mx));
                idle(kd - 1);
                pulse_kill();
            end
`else
            mx = 0;
            kd = 0;
`endif
            gap = int'($urandom_range(0, 3));
            if (gap > 0) idle(gap + mx + kd);
        end
        idle(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fork_join_scheduler.md
# fork_join_scheduler

Hardware fork/join controller. Accepts one fork command that launches up to N_TASKS concurrent timed jobs, each of programmable duration, and reports the join point per the selected mode: JOIN (all jobs finished), JOIN_ANY (first finished) or JOIN_NONE (immediately after launch). It sits between a sequencing master and a bank of worker timers and owns each worker's start/active/done signalling.

## Interface
- N_TASKS, 2: number of workers.
- DUR_W, 8: duration field width per task, in cycles.
- clk  in  1  clock.
- rst  in  1  reset; one clock, asynchronous, active-high.
- fork_valid  in  1  fork command valid.
- fork_ready  out  1  high only in IDLE.
- fork_mode  in  2  0=JOIN, 1=JOIN_ANY, 2=JOIN_NONE, 3=reserved (treated as JOIN).
- fork_mask  in  N_TASKS  tasks to launch.
- fork_dur  in  N_TASKS*DUR_W  duration per task; task i at [i*DUR_W +: DUR_W].
- task_start  out  N_TASKS  one-cycle launch pulse.
- task_active  out  N_TASKS  task running.
- task_done  out  N_TASKS  one-cycle completion pulse.
- join_done  out  1  one-cycle join-point pulse per fork.
- kill  in  1  abort all running tasks (FORK_DISABLE_EN only).
- fork_killed  out  1  one-cycle abort pulse (FORK_DISABLE_EN only).

## Operation
- States: IDLE -> RUN on accept (fork_valid & fork_ready). RUN -> DRAIN when join condition met and tasks remain active. RUN or DRAIN -> IDLE when no task is active or finishing.
- Accept latches mask, mode and durations. Commands are not accepted outside IDLE; fork_valid is held by the master.
- Task i with mask bit set: task_start[i] pulses, then task_active[i] is high for D_i cycles, then task_done[i] pulses with task_active[i] low.
- D_i = 0: task_start and task_done pulse in the same cycle; task_active never rises.
- Join condition:
  - JOIN: the cycle of the last task_done.
  - JOIN_ANY: the cycle of the first task_done. Ties produce a single join_done.
  - JOIN_NONE: the task_start cycle.
- Empty mask: join_done pulses once in the cycle after accept for all modes; no task signals toggle; back to IDLE.
- Exactly one join_done per accepted fork, never re-asserted in DRAIN.
- Reset (asynchronous, any state): state IDLE, all counters cleared, no done or join pulses. Reset values: fork_ready=1, and task_start, task_active, task_done, join_done, fork_killed all 0.

## Timing
- Accept at edge T: task_start in cycle T+1.
- task_done[i] in cycle T+1+D_i.
- join_done in cycle T+1+max(D) for JOIN, T+1+min(D over mask) for JOIN_ANY, T+1 for JOIN_NONE.
- fork_ready rises in cycle T+2+max(D). Earliest next accept is at the end of that cycle.
- All outputs are registered; no combinational path from inputs to outputs except none. fork_ready is decoded from the state register.

## Configuration
- FORK_DISABLE_EN defined: kill and fork_killed ports exist.
  - kill in RUN or DRAIN: all task_active clear next cycle, fork_killed pulses in that cycle, state returns to IDLE. No task_done for killed tasks; join_done is suppressed if not yet issued.
  - kill in a cycle where task_done[i] is also due: that task_done still pulses, and it counts toward join.
  - kill in IDLE: ignored.
- FORK_DISABLE_EN undefined: ports absent; every fork runs to completion.

## Structure
- Package fork_pkg: fork_mode_e enum (JOIN, JOIN_ANY, JOIN_NONE), fsm state enum (IDLE, RUN, DRAIN), default DUR_W.
- Sub-module task_timer: one per task, generate loop. Inputs: load, duration, clear. Outputs: start, active, done pulses.
- The top holds the FSM, command latch and join logic.

## Test plan
- JOIN, mask=2'b11, dur={30,20}, accept T=0 -> task_start=11 @1; done[0] @21; done[1] @31; join_done @31; fork_ready @32.
- JOIN_NONE, same durations -> join_done @1 alongside task_start; done[0] @21, done[1] @31; fork_ready @32; second fork_valid held from @5 accepted at end of @32.
- JOIN_ANY, dur={5,5} -> both task_done @6, single join_done @6. Also mask=0 -> join_done @1 only, no task pulses.
- Durations {0,3}, JOIN -> start and done[0] @1 with active[0] never high; done[1] and join_done @4.
- Reset asserted @10 during JOIN run -> all outputs 0 and fork_ready=1 immediately; no join_done afterwards.
- FORK_DISABLE_EN, JOIN {30,20}, kill @21 (coincides with done[0]) -> done[0] @21, active[1] low and fork_killed @22, no join_done, fork_ready @23.
